// File: rtl/regfile_sched_pkg.sv
// Shared widths and state encoding for the register-file write-port scheduler.
package regfile_sched_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] LAST_REG = 5'd31;

    typedef enum logic {
        INIT,
        RUN
    } state_e;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the search starts one past the last winner.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int LW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [LW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [LW-1:0] idx_o,
    output logic          any_o
);
    int          c;
    logic [LW-1:0] ci;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        c     = 0;
        ci    = '0;
        for (int k = 1; k <= N; k++) begin
            // Wrap modulo N rather than modulo a power of two.
            c = int'(last_i) + k;
            if (c >= N) c = c - N;
            ci = LW'(c);
            if (!any_o && req_i[ci]) begin
                any_o     = 1'b1;
                gnt_o[ci] = 1'b1;
                idx_o     = ci;
            end
        end
    end
endmodule

// File: rtl/regfile_write_sched.sv
// Write-port scheduler: clears r1..r31 after reset/flush, then arbitrates
// writeback requesters round-robin onto the single register-file write port.
module regfile_write_sched
    import regfile_sched_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                      Clk,
    input  logic                      ResetN,
    input  logic                      Flush,
    input  logic [NUM_REQ-1:0]        ReqValid,
    input  logic [ADDR_W*NUM_REQ-1:0] ReqAddr,
    input  logic [DATA_W*NUM_REQ-1:0] ReqData,
    output logic [NUM_REQ-1:0]        ReqReady,
    output logic [ADDR_W-1:0]         WriteRegister,
    output logic [DATA_W-1:0]         WriteData,
    output logic                      RegWrite,
    output logic                      InitDone
);
    localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [LW-1:0] LAST_RST = LW'(NUM_REQ - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [LW-1:0]       last_q, last_d;
    logic                rw_q, rw_d;
    logic [ADDR_W-1:0]   wreg_q, wreg_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                done_q, done_d;

    logic [NUM_REQ-1:0]  gnt;
    logic [LW-1:0]       gidx;
    logic                gany;
    logic [ADDR_W-1:0]   addr_a [NUM_REQ];
    logic [DATA_W-1:0]   data_a [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign addr_a[i] = ReqAddr[i*ADDR_W +: ADDR_W];
        assign data_a[i] = ReqData[i*DATA_W +: DATA_W];
    end

    rr_arbiter #(.N(NUM_REQ), .LW(LW)) u_arb (
        .req_i  (ReqValid),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (gidx),
        .any_o  (gany)
    );

    // Flush masks every grant so no request is consumed while restarting.
    assign ReqReady = (state_q == RUN && !Flush) ? gnt : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        rw_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        done_d  = done_q;
        unique case (state_q)
            INIT: begin
                if (Flush) begin
                    cnt_d = 5'd1;
                end else begin
                    rw_d    = 1'b1;
                    wreg_d  = cnt_q;
                    wdata_d = '0;
                    if (cnt_q == LAST_REG) begin
                        state_d = RUN;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            RUN: begin
                if (Flush) begin
                    state_d = INIT;
                    cnt_d   = 5'd1;
                    done_d  = 1'b0;
                end else if (gany) begin
                    // r0 is hardwired zero: accept the request but suppress the write.
                    rw_d    = (addr_a[gidx] != '0);
                    wreg_d  = addr_a[gidx];
                    wdata_d = data_a[gidx];
                    last_d  = gidx;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= INIT;
            cnt_q   <= 5'd1;
            last_q  <= LAST_RST;
            rw_q    <= 1'b0;
            wreg_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rw_q    <= rw_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
        end
    end

    assign RegWrite      = rw_q;
    assign WriteRegister = wreg_q;
    assign WriteData     = wdata_q;
    assign InitDone      = done_q;
endmodule

// File: tb/tb_regfile_write_sched.sv
// Directed bench for regfile_write_sched (NUM_REQ=2 and NUM_REQ=3 instances).
module tb_regfile_write_sched;
    logic        Clk = 1'b0;
    logic        ResetN, ResetN3, Flush, Flush3;
    logic [1:0]  ReqValid;
    logic [9:0]  ReqAddr;
    logic [63:0] ReqData;
    logic [1:0]  ReqReady;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite, InitDone;

    logic [2:0]  ReqValid3;
    logic [14:0] ReqAddr3;
    logic [95:0] ReqData3;
    logic [2:0]  ReqReady3;
    logic [4:0]  WriteRegister3;
    logic [31:0] WriteData3;
    logic        RegWrite3, InitDone3;

    typedef struct {
        logic        rw;
        logic [4:0]  wr;
        logic [31:0] wd;
        bit          full;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    bit   sel = 1'b0;

    logic [7:0]  obs_rdy;
    logic        obs_rw, obs_done;
    logic [4:0]  obs_wr;
    logic [31:0] obs_wd;

    always #5 Clk = ~Clk;

    regfile_write_sched #(.NUM_REQ(2)) dut (
        .Clk(Clk), .ResetN(ResetN), .Flush(Flush),
        .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqData(ReqData),
        .ReqReady(ReqReady), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .RegWrite(RegWrite), .InitDone(InitDone)
    );

    regfile_write_sched #(.NUM_REQ(3)) dut3 (
        .Clk(Clk), .ResetN(ResetN3), .Flush(Flush3),
        .ReqValid(ReqValid3), .ReqAddr(ReqAddr3), .ReqData(ReqData3),
        .ReqReady(ReqReady3), .WriteRegister(WriteRegister3),
        .WriteData(WriteData3), .RegWrite(RegWrite3), .InitDone(InitDone3)
    );

    always_comb begin
        obs_rdy  = sel ? {5'd0, ReqReady3} : {6'd0, ReqReady};
        obs_rw   = sel ? RegWrite3 : RegWrite;
        obs_wr   = sel ? WriteRegister3 : WriteRegister;
        obs_wd   = sel ? WriteData3 : WriteData;
        obs_done = sel ? InitDone3 : InitDone;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check ready before the edge, queue the expected write, compare it after the edge.
    task automatic tick(input logic [7:0] exp_rdy, input logic exp_rw, input logic [4:0] exp_wr,
                        input logic [31:0] exp_wd, input bit full, input string tag);
        exp_t e;
        #2;
        chk({tag, ".rdy"}, {24'd0, obs_rdy}, {24'd0, exp_rdy});
        e.rw = exp_rw; e.wr = exp_wr; e.wd = exp_wd; e.full = full; e.tag = tag;
        sb.push_back(e);
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".rw"}, {31'd0, obs_rw}, {31'd0, e.rw});
        if (e.full) begin
            chk({e.tag, ".wr"}, {27'd0, obs_wr}, {27'd0, e.wr});
            chk({e.tag, ".wd"}, obs_wd, e.wd);
        end
    endtask

    task automatic clear_seq(input string tag);
        for (int i = 1; i <= 31; i++) begin
            tick(8'h0, 1'b1, 5'(i), 32'd0, 1'b1, tag);
            if (i == 30 || i == 31)
                chk({tag, ".done"}, {31'd0, obs_done}, {31'd0, (i == 31)});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ResetN = 1'b0; ResetN3 = 1'b0; Flush = 1'b0; Flush3 = 1'b0;
        ReqValid = '0; ReqAddr = '0; ReqData = '0;
        ReqValid3 = '0; ReqAddr3 = '0; ReqData3 = '0;
        @(negedge Clk);
        chk("rst.rw", {31'd0, RegWrite}, 32'd0);
        chk("rst.wr", {27'd0, WriteRegister}, 32'd0);
        chk("rst.wd", WriteData, 32'd0);
        chk("rst.done", {31'd0, InitDone}, 32'd0);
        chk("rst.rdy", {30'd0, ReqReady}, 32'd0);
        @(negedge Clk);
        ResetN = 1'b1;

        clear_seq("init");
        tick(8'h0, 1'b0, 5'd0, 32'd0, 1'b0, "idle");
        chk("idle.done", {31'd0, InitDone}, 32'd1);

        // Alternating grants with both requesters held valid.
        ReqAddr = {5'd3, 5'd2};
        ReqData = {32'd15, 32'd42};
        ReqValid = 2'b11;
        tick(8'h1, 1'b1, 5'd2, 32'd42, 1'b1, "rr0");
        tick(8'h2, 1'b1, 5'd3, 32'd15, 1'b1, "rr1");
        tick(8'h1, 1'b1, 5'd2, 32'd42, 1'b1, "rr2");
        tick(8'h2, 1'b1, 5'd3, 32'd15, 1'b1, "rr3");
        ReqValid = 2'b00;
        tick(8'h0, 1'b0, 5'd0, 32'd0, 1'b0, "rr_idle");

        // Write to r0 is accepted but dropped.
        ReqValid = 2'b01; ReqAddr = {5'd0, 5'd0}; ReqData = {32'd0, 32'd99};
        tick(8'h1, 1'b0, 5'd0, 32'd99, 1'b1, "r0");
        ReqAddr = {5'd0, 5'd5}; ReqData = {32'd0, 32'd7};
        tick(8'h1, 1'b1, 5'd5, 32'd7, 1'b1, "after_r0");
        ReqValid = 2'b00;
        tick(8'h0, 1'b0, 5'd0, 32'd0, 1'b0, "r0_idle");

        // Flush in RUN with req0 held valid throughout.
        ReqValid = 2'b01; ReqAddr = {5'd0, 5'd9}; ReqData = {32'd0, 32'h1234};
        Flush = 1'b1;
        tick(8'h0, 1'b0, 5'd0, 32'd0, 1'b0, "flush_run");
        chk("flush_run.done", {31'd0, InitDone}, 32'd0);
        Flush = 1'b0;
        clear_seq("reinit");
        tick(8'h1, 1'b1, 5'd9, 32'h1234, 1'b1, "held_req");
        ReqValid = 2'b00;

        // Flush in RUN, then flush again in INIT once Cnt has reached 10.
        Flush = 1'b1;
        tick(8'h0, 1'b0, 5'd0, 32'd0, 1'b0, "flush_run2");
        Flush = 1'b0;
        for (int i = 1; i <= 9; i++) tick(8'h0, 1'b1, 5'(i), 32'd0, 1'b1, "part");
        Flush = 1'b1;
        tick(8'h0, 1'b0, 5'd0, 32'd0, 1'b0, "flush_init");
        chk("flush_init.done", {31'd0, InitDone}, 32'd0);
        Flush = 1'b0;
        clear_seq("restart");

        // NUM_REQ=3: pointer wraps 2 -> 0.
        sel = 1'b1;
        @(negedge Clk);
        ResetN3 = 1'b1;
        clear_seq("n3init");
        ReqAddr3 = {5'd7, 5'd6, 5'd4};
        ReqData3 = {32'hC2, 32'hB1, 32'hA0};
        ReqValid3 = 3'b100;
        tick(8'h4, 1'b1, 5'd7, 32'hC2, 1'b1, "n3_req2");
        ReqValid3 = 3'b011;
        tick(8'h1, 1'b1, 5'd4, 32'hA0, 1'b1, "n3_wrap");
        ReqValid3 = 3'b111;
        tick(8'h2, 1'b1, 5'd6, 32'hB1, 1'b1, "n3_req1");
        ResetN3 = 1'b0;
        #1;
        chk("arst.rw", {31'd0, RegWrite3}, 32'd0);
        chk("arst.wr", {27'd0, WriteRegister3}, 32'd0);
        chk("arst.wd", WriteData3, 32'd0);
        chk("arst.done", {31'd0, InitDone3}, 32'd0);
        chk("arst.rdy", {29'd0, ReqReady3}, 32'd0);
        ReqValid3 = '0;
        #2;
        ResetN3 = 1'b1;
        @(posedge Clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/regfile_write_sched.md
# regfile_write_sched

Write-port scheduler for the 32x32 register file. After reset or on flush it zeroes registers 1..31 through the single write port. It then shares that port among `NUM_REQ` writeback requesters using valid/ready handshakes and round-robin arbitration. It sits between the writeback sources and the register file's `WriteData`/`WriteRegister`/`RegWrite` inputs; all three outputs are registered.

## Interface
- `NUM_REQ`, default 2: number of writeback requesters, 2..8.
- `Clk`  in  1: clock; the register file samples this block's outputs on the same posedge.
- `ResetN`  in  1: asynchronous, active-low reset.
- `Flush`  in  1: synchronous request to restart the clear sequence.
- `ReqValid`  in  `NUM_REQ`: requester i has a write pending.
- `ReqAddr`  in  `5*NUM_REQ`: requester i destination register, bits [5i+4:5i].
- `ReqData`  in  `32*NUM_REQ`: requester i write data, bits [32i+31:32i].
- `ReqReady`  out  `NUM_REQ`: one-hot or zero; the write is accepted when valid and ready are both high at a posedge.
- `WriteRegister`  out  5: to regfile.
- `WriteData`  out  32: to regfile.
- `RegWrite`  out  1: to regfile.
- `InitDone`  out  1: high while in RUN.

## Operation
- States: INIT, RUN.
- On reset: state=INIT, clear counter `Cnt`=1, round-robin pointer `Last`=`NUM_REQ`-1.
  - Output reset values: `RegWrite`=0, `WriteRegister`=0, `WriteData`=0, `InitDone`=0.
- **INIT**
  - Each cycle, the outputs load `RegWrite`=1, `WriteRegister`=`Cnt`, `WriteData`=0, and `Cnt` increments.
  - When `Cnt`=31 is loaded, the state moves to RUN and `InitDone`=1 on that same edge.
  - `ReqReady`=0 throughout INIT.
- **RUN, arbitration**
  - Candidates are the requesters with `ReqValid` set.
  - Priority order is `Last`+1, `Last`+2, … modulo `NUM_REQ`; the first valid candidate is granted.
  - `ReqReady`[g]=1 combinationally for the granted requester only.
  - `Last` updates to g only on a transfer.
  - No valid requesters: `ReqReady`=0, `Last` holds, and `RegWrite` loads 0.
- **RUN, transfer**
  - The outputs load `RegWrite`=1, `WriteRegister`=`ReqAddr`[g], `WriteData`=`ReqData`[g].
  - If `ReqAddr`[g]=0, the request is still accepted (ready=1) but `RegWrite` loads 0, so the write is dropped. `WriteRegister` and `WriteData` load the request values anyway.
- **Flush**
  - Flush has priority over grants: `ReqReady`=0 in any cycle with `Flush`=1.
  - Flush in RUN: next state INIT, `Cnt`=1, `InitDone` cleared on that edge, and `RegWrite` loads 0 on that edge.
  - Flush in INIT: `Cnt` reloads to 1 and `RegWrite` loads 0 on that edge; the sequence restarts.
  - `Last` is unaffected by flush.
- **Requester rules**
  - Once `ReqValid`=1 is asserted, the requester holds valid, addr and data stable until accepted.
  - `ReqReady` may depend combinationally on `ReqValid`; requesters must not make valid depend on ready.
- Arithmetic:
  - `Cnt` is 5 bits and never wraps, because INIT exits at 31.
  - `Last` arithmetic is modulo `NUM_REQ`, not power-of-two, so `NUM_REQ`=3 wraps 2→0.

## Timing
- Latency: a request accepted at edge N appears on the outputs after edge N and is committed to the regfile at edge N+1.
- Throughput: one write per cycle in RUN.
- Clear sequence: exactly 31 consecutive `RegWrite` cycles (addresses 1..31) starting with the first posedge after `ResetN` rises.
  - `InitDone` rises coincident with address 31 being driven.
  - The first request can be accepted in that same cycle.
- Reset asserted mid-operation: all outputs drop to reset values immediately (asynchronously), and any write in flight is lost.
- `ReqReady` is combinational from `ReqValid`, state, `Flush` and `Last`; all outputs except `ReqReady` are flops.

## Structure
- Package `regfile_sched_pkg`:
  - `ADDR_W`=5, `DATA_W`=32, `LAST_REG`=31.
  - State enum {INIT, RUN}.
- Sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: request vector, `Last` pointer.
  - Outputs: one-hot grant, encoded index, any-grant.
  - Purely combinational; `Last` is held in the parent.

## Test plan
- Reset release, no requests:
  - `RegWrite`=1 for exactly 31 cycles with `WriteRegister` 1..31 and `WriteData`=0.
  - `InitDone` rises on the address-31 cycle.
  - `RegWrite`=0 afterward.
- RUN with `ReqValid`=2'b11 held for 4 cycles, req0 (addr 2, data 42) and req1 (addr 3, data 15):
  - Grants alternate 0,1,0,1, starting with req0.
  - Outputs follow one cycle later: (2,42),(3,15),(2,42),(3,15).
- Request with addr 0, data 99:
  - `ReqReady`=1 the same cycle; `RegWrite`=0 the next cycle.
  - The next request (addr 5, data 7) writes normally.
- `Flush` in RUN while req0 is valid:
  - `ReqReady`=0 that cycle and `InitDone` falls.
  - The 31-write zero sequence repeats.
  - The request held throughout is accepted in the first RUN cycle.
- `Flush` in INIT when `Cnt`=10: the sequence restarts at address 1, giving 31 more clear writes.
- `NUM_REQ`=3, with req2 then req0 valid: the pointer wraps 2→0 and the grant order is req2 then req0; `ResetN` pulsed low mid-stream returns all outputs to 0 immediately.
